ii_pulse_checker: RTL

- Receive-side companion to the every-II pulse generators: watches a start strobe and a pulse stream and checks that exactly N pulses arrive, spaced exactly II clocks apart, with the first pulse in the start cycle.
- Reports done, a sticky error with a cause code, and the accepted-pulse count.
- Used in scheduled datapaths as an in-line monitor and in benches as a scoreboard for pulse-train producers.

---
 rtl/ii_pulse_checker_if.sv | 32 +++
 rtl/ii_pulse_checker.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ii_pulse_checker_if.sv
// Handshake bundle between a pulse-train producer/observer and ii_pulse_checker.
// Groups the stimulus (start, pulse) and the checker status (busy, done, err, err_code, pulse_cnt).
// master drives start/pulse and reads status; slave is the checker side.
interface ii_pulse_checker_if;
  logic        start;
  logic        pulse;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] pulse_cnt;

  modport master (
    output start,
    output pulse,
    input  busy,
    input  done,
    input  err,
    input  err_code,
    input  pulse_cnt
  );

  modport slave (
    input  start,
    input  pulse,
    output busy,
    output done,
    output err,
    output err_code,
    output pulse_cnt
  );
endinterface

// File: rtl/ii_pulse_checker.sv
// Checks that exactly N pulses arrive II clocks apart, first pulse in the start cycle.
// Latency: decision in the cycle a pulse arrives or is due, visible on outputs 1 clock later.
// Backpressure: none; the pulse stream cannot be stalled, violations latch a sticky error.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   chk.start    opens a new check window (pulse required in the same cycle)
//   chk.pulse    observed pulse stream
//   chk.busy     window open, more pulses expected
//   chk.done     N pulses accepted with correct spacing, held until next start
//   chk.err      sticky violation, held until next start
//   chk.err_code 00 none, 01 LATE, 10 EARLY, 11 EXTRA
//   chk.pulse_cnt pulses accepted in the current window
module ii_pulse_checker #(
  parameter int N  = 2,
  parameter int II = 1
) (
  input  logic               clk,
  input  logic               rst,
  ii_pulse_checker_if.slave  chk
);

  localparam logic [31:0] N_W  = 32'(N);
  localparam logic [31:0] II_W = 32'(II);

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_LATE  = 2'b01;
  localparam logic [1:0] CODE_EARLY = 2'b10;
  localparam logic [1:0] CODE_EXTRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] cnt_q, cnt_d;
  // clocks since the last accepted pulse; RUN leaves at elapsed==II so it never wraps
  logic [31:0] elapsed_q, elapsed_d;
  logic [31:0] cnt_inc;

  assign cnt_inc = cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      code_q    <= CODE_NONE;
      cnt_q     <= '0;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    elapsed_d = elapsed_q;

    if (chk.start) begin
      // start wins in every state and restarts the window
      if (chk.pulse) begin
        cnt_d     = 32'd1;
        elapsed_d = 32'd1;
        code_d    = CODE_NONE;
        state_d   = (N_W == 32'd1) ? DONE : RUN;
      end else begin
        cnt_d   = '0;
        code_d  = CODE_LATE;
        state_d = ERR;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // stray pulses before any start are not checked
        end
        RUN: begin
          if (chk.pulse && (elapsed_q < II_W)) begin
            code_d  = CODE_EARLY;
            state_d = ERR;
          end else if (chk.pulse) begin
            cnt_d     = cnt_inc;
            elapsed_d = 32'd1;
            if (cnt_inc == N_W) begin
              state_d = DONE;
            end
          end else if (elapsed_q == II_W) begin
            code_d  = CODE_LATE;
            state_d = ERR;
          end else begin
            elapsed_d = elapsed_q + 32'd1;
          end
        end
        DONE: begin
          if (chk.pulse) begin
            code_d  = CODE_EXTRA;
            state_d = ERR;
          end
        end
        ERR: begin
          // frozen until the next start
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // status is decoded from registered state only, so inputs never reach outputs combinationally
  assign chk.busy      = (state_q == RUN);
  assign chk.done      = (state_q == DONE);
  assign chk.err       = (state_q == ERR);
  assign chk.err_code  = code_q;
  assign chk.pulse_cnt = cnt_q;

endmodule
